multicycle_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences a shared multicycle MIPS-subset datapath: one memory, one ALU, one register file, one 16-to-32 immediate extender.
- Decodes the IR opcode and steps each instruction through fetch/decode/execute/memory/writeback.
- Qualifies memory steps on a ready handshake.
- Drives the extender mode (sign vs zero) per opcode and counts retired instructions.

---
 rtl/ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_out_decode.sv | 102 ++++++++++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// and the datapath mux/op codes driven by the control outputs.
package ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RST      = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WB   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_R_EXEC   = 4'd7,
      ST_R_WB     = 4'd8,
      ST_I_EXEC   = 4'd9,
      ST_I_WB     = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JUMP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_IMM   = 2'd3;

   localparam logic [1:0] SRCB_RT      = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Wide enough for the largest allowed wait limit (31).
   localparam int WAIT_W = 5;

   function automatic logic op_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
   function automatic logic op_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-output map: (state, opcode, zero, mem_ready) -> datapath
// controls. Unlisted outputs stay 0 in every state.
module ctrl_out_decode
   import ctrl_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       ir_write_o,
   output logic       iord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ext_zero_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic [1:0] pc_src_o,
   output logic       illegal_o
);

   always_comb begin
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ext_zero_o   = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_RT;
      alu_op_o     = ALU_ADD;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      pc_src_o     = PCSRC_ALU;
      illegal_o    = 1'b0;
      case (state_i)
         ST_FETCH: begin
            // PC+4 and IR load only in the cycle the memory delivers.
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            pc_write_o  = mem_ready_i;
            ir_write_o  = mem_ready_i;
         end
         ST_DECODE: begin
            alu_src_b_o = SRCB_IMM_SH2;
            illegal_o   = !op_legal(opcode_i);
         end
         ST_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
         end
         ST_MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         ST_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         ST_MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
         end
         ST_R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_FUNCT;
         end
         ST_R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
         end
         ST_I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALU_IMM;
            ext_zero_o  = op_zero_ext(opcode_i);
         end
         ST_I_WB: begin
            reg_write_o = 1'b1;
            ext_zero_o  = op_zero_ext(opcode_i);
         end
         ST_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_SUB;
            pc_src_o    = PCSRC_ALUOUT;
            pc_write_o  = ((opcode_i == OP_BEQ) && zero_i) ||
                          ((opcode_i == OP_BNE) && !zero_i);
         end
         ST_JUMP: begin
            pc_src_o   = PCSRC_JUMP;
            pc_write_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: state register, next-state logic, memory
// wait/timeout counter and retired-instruction counter.
module multicycle_ctrl #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             ext_zero_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic [1:0]       pc_src_o,
   output logic             illegal_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] instr_cnt_o,
   output logic [3:0]       state_o
);
   import ctrl_pkg::*;

   localparam logic [WAIT_W-1:0] LIMIT_M1 = WAIT_W'(WAIT_LIMIT - 1);

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                waiting;
   logic                timeout;
   logic                retire;

   // Memory handshake: a request (mem_read_o/mem_write_o) is held while
   // mem_ready_i=0; the access completes in the cycle mem_ready_i=1 is seen
   // with the request up. Ready in the limit cycle beats the timeout.
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      waiting = is_wait_state(state_q);
      timeout = waiting && !mem_ready_i && (wait_q == LIMIT_M1);
      case (state_q)
         ST_RST:      state_d = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready_i)  state_d = ST_DECODE;
            else if (timeout) state_d = ST_FETCH;
         end
         ST_DECODE: begin
            case (opcode_i)
               OP_RTYPE:                          state_d = ST_R_EXEC;
               OP_LW, OP_SW:                      state_d = ST_MEM_ADDR;
               OP_BEQ, OP_BNE:                    state_d = ST_BRANCH;
               OP_J:                              state_d = ST_JUMP;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_I_EXEC;
               default:                           state_d = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR: state_d = (opcode_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: begin
            if (mem_ready_i)  state_d = ST_MEM_WB;
            else if (timeout) state_d = ST_FETCH;
         end
         ST_MEM_WR: begin
            if (mem_ready_i) begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d = ST_FETCH;
            end
         end
         ST_R_EXEC:   state_d = ST_R_WB;
         ST_I_EXEC:   state_d = ST_I_WB;
         ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         default:     state_d = ST_RST;
      endcase

      // Count only cycles spent re-waiting in the same memory state.
      if (waiting && (state_d == state_q) && !timeout) wait_d = wait_q + 1'b1;
      else                                             wait_d = '0;

      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RST;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   ctrl_out_decode u_decode (
      .state_i      (state_q),
      .opcode_i     (opcode_i),
      .zero_i       (zero_i),
      .mem_ready_i  (mem_ready_i),
      .pc_write_o   (pc_write_o),
      .ir_write_o   (ir_write_o),
      .iord_o       (iord_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .ext_zero_o   (ext_zero_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .alu_op_o     (alu_op_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_write_o  (reg_write_o),
      .pc_src_o     (pc_src_o),
      .illegal_o    (illegal_o)
   );

   assign timeout_o   = timeout;
   assign instr_cnt_o = cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written wait/timeout
// sequences, then random stimulus against an instruction-step queue model.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int WAIT_LIMIT = 16;
   localparam int CNT_W      = 32;

   logic             clk;
   logic             rst_i;
   logic [5:0]       opcode_i;
   logic             zero_i;
   logic             mem_ready_i;
   logic             pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
   logic             ext_zero_o, alu_src_a_o, reg_dst_o, mem_to_reg_o;
   logic             reg_write_o, illegal_o, timeout_o;
   logic [1:0]       alu_src_b_o, alu_op_o, pc_src_o;
   logic [CNT_W-1:0] instr_cnt_o;
   logic [3:0]       state_o;

   multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
      .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
      .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .ext_zero_o(ext_zero_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
      .reg_write_o(reg_write_o), .pc_src_o(pc_src_o), .illegal_o(illegal_o),
      .timeout_o(timeout_o), .instr_cnt_o(instr_cnt_o), .state_o(state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write, ir_write, iord, mem_read, mem_write, ext_zero, alu_src_a;
      logic [1:0] alu_src_b, alu_op;
      logic       reg_dst, mem_to_reg, reg_write;
      logic [1:0] pc_src;
      logic       illegal, timeout;
   } outs_t;

   outs_t act;
   assign act = {pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, ext_zero_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
                 reg_write_o, pc_src_o, illegal_o, timeout_o};

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       zero;
      logic       rdy;
      state_t     st;
      int         cnt;
      outs_t      o;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [5:0] legal_ops[10];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // expected output bundles, one per state as described by the datapath contract
   function automatic outs_t e_fetch(input logic rdy);
      outs_t o = '0; o.mem_read = 1; o.alu_src_b = 2'd1; o.pc_write = rdy; o.ir_write = rdy;
      return o;
   endfunction
   function automatic outs_t e_decode(input logic ill);
      outs_t o = '0; o.alu_src_b = 2'd3; o.illegal = ill; return o;
   endfunction
   function automatic outs_t e_mem_addr();
      outs_t o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2; return o;
   endfunction
   function automatic outs_t e_mem_rd();
      outs_t o = '0; o.mem_read = 1; o.iord = 1; return o;
   endfunction
   function automatic outs_t e_mem_wb();
      outs_t o = '0; o.reg_write = 1; o.mem_to_reg = 1; return o;
   endfunction
   function automatic outs_t e_mem_wr();
      outs_t o = '0; o.mem_write = 1; o.iord = 1; return o;
   endfunction
   function automatic outs_t e_r_exec();
      outs_t o = '0; o.alu_src_a = 1; o.alu_op = 2'd2; return o;
   endfunction
   function automatic outs_t e_r_wb();
      outs_t o = '0; o.reg_write = 1; o.reg_dst = 1; return o;
   endfunction
   function automatic outs_t e_i_exec(input logic ez);
      outs_t o = '0; o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 2'd3; o.ext_zero = ez;
      return o;
   endfunction
   function automatic outs_t e_i_wb(input logic ez);
      outs_t o = '0; o.reg_write = 1; o.ext_zero = ez; return o;
   endfunction
   function automatic outs_t e_branch(input logic pcw);
      outs_t o = '0; o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_src = 2'd1; o.pc_write = pcw;
      return o;
   endfunction
   function automatic outs_t e_jump();
      outs_t o = '0; o.pc_src = 2'd2; o.pc_write = 1; return o;
   endfunction

   function automatic logic tb_legal(input logic [5:0] op);
      for (int k = 0; k < 10; k++) if (legal_ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                      input logic rdy, input state_t st, input int cnt, input outs_t o);
      vec_t v;
      v.rst = rst; v.op = op; v.zero = zero; v.rdy = rdy; v.st = st; v.cnt = cnt; v.o = o;
      vecs.push_back(v);
   endtask

   // driver: inputs change at negedge, outputs sampled 1 time unit later
   task automatic drive(input logic rst, input logic [5:0] op, input logic zero, input logic rdy);
      @(negedge clk);
      rst_i = rst; opcode_i = op; zero_i = zero; mem_ready_i = rdy;
      #1;
   endtask

   initial begin
      state_t     m_st;
      state_t     m_plan[$];
      int         m_wait;
      logic [CNT_W-1:0] m_cnt;
      int         stall_left;
      logic       r, rdy, z, exp_to, exp_pcw, done;
      logic [5:0] op;
      logic [5:0] exp_flags, got_flags;

      legal_ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                    OP_ANDI, OP_ORI, OP_LW, OP_SW};
      rst_i = 1'b1; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
      repeat (2) @(posedge clk);

      // ---------------- directed vector table ----------------
      add(1, OP_RTYPE, 0, 1, ST_RST, 0, '0);
      add(0, OP_RTYPE, 0, 1, ST_RST, 0, '0);
      add(0, OP_RTYPE, 0, 1, ST_FETCH, 0, e_fetch(1));
      add(0, OP_RTYPE, 0, 1, ST_DECODE, 0, e_decode(0));
      add(0, OP_RTYPE, 0, 1, ST_R_EXEC, 0, e_r_exec());
      add(0, OP_RTYPE, 0, 1, ST_R_WB, 0, e_r_wb());
      add(0, OP_LW, 0, 1, ST_FETCH, 1, e_fetch(1));
      add(0, OP_LW, 0, 1, ST_DECODE, 1, e_decode(0));
      add(0, OP_LW, 0, 1, ST_MEM_ADDR, 1, e_mem_addr());
      for (int k = 0; k < 3; k++) add(0, OP_LW, 0, 0, ST_MEM_RD, 1, e_mem_rd());
      add(0, OP_LW, 0, 1, ST_MEM_RD, 1, e_mem_rd());
      add(0, OP_LW, 0, 1, ST_MEM_WB, 1, e_mem_wb());
      add(0, OP_BEQ, 1, 1, ST_FETCH, 2, e_fetch(1));
      add(0, OP_BEQ, 1, 1, ST_DECODE, 2, e_decode(0));
      add(0, OP_BEQ, 1, 1, ST_BRANCH, 2, e_branch(1));
      add(0, OP_BNE, 1, 1, ST_FETCH, 3, e_fetch(1));
      add(0, OP_BNE, 1, 1, ST_DECODE, 3, e_decode(0));
      add(0, OP_BNE, 1, 1, ST_BRANCH, 3, e_branch(0));
      add(0, OP_ORI, 0, 1, ST_FETCH, 4, e_fetch(1));
      add(0, OP_ORI, 0, 1, ST_DECODE, 4, e_decode(0));
      add(0, OP_ORI, 0, 1, ST_I_EXEC, 4, e_i_exec(1));
      add(0, OP_ORI, 0, 1, ST_I_WB, 4, e_i_wb(1));
      add(0, OP_ADDI, 0, 1, ST_FETCH, 5, e_fetch(1));
      add(0, OP_ADDI, 0, 1, ST_DECODE, 5, e_decode(0));
      add(0, OP_ADDI, 0, 1, ST_I_EXEC, 5, e_i_exec(0));
      add(0, OP_ADDI, 0, 1, ST_I_WB, 5, e_i_wb(0));
      add(0, 6'h3F, 0, 1, ST_FETCH, 6, e_fetch(1));
      add(0, 6'h3F, 0, 1, ST_DECODE, 6, e_decode(1));
      add(0, OP_SW, 0, 1, ST_FETCH, 6, e_fetch(1));
      add(0, OP_SW, 0, 1, ST_DECODE, 6, e_decode(0));
      add(0, OP_SW, 0, 1, ST_MEM_ADDR, 6, e_mem_addr());
      add(0, OP_SW, 0, 0, ST_MEM_WR, 6, e_mem_wr());
      add(0, OP_SW, 0, 1, ST_MEM_WR, 6, e_mem_wr());
      add(0, OP_J, 0, 1, ST_FETCH, 7, e_fetch(1));
      add(0, OP_J, 0, 1, ST_DECODE, 7, e_decode(0));
      add(0, OP_J, 0, 1, ST_JUMP, 7, e_jump());
      add(0, OP_SW, 0, 1, ST_FETCH, 8, e_fetch(1));
      add(0, OP_SW, 0, 1, ST_DECODE, 8, e_decode(0));
      add(0, OP_SW, 0, 1, ST_MEM_ADDR, 8, e_mem_addr());
      add(1, OP_SW, 0, 0, ST_MEM_WR, 8, e_mem_wr());
      add(0, OP_SW, 0, 0, ST_RST, 0, '0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].rdy);
         chk($sformatf("vec%0d state", i), 64'(state_o), 64'(vecs[i].st));
         chk($sformatf("vec%0d instr_cnt", i), 64'(instr_cnt_o), 64'(vecs[i].cnt));
         chk($sformatf("vec%0d outputs", i), 64'(act), 64'(vecs[i].o));
      end

      // ---------------- fetch timeout: 16 not-ready cycles ----------------
      for (int k = 0; k < WAIT_LIMIT; k++) begin
         drive(0, OP_RTYPE, 0, 0);
         chk($sformatf("to_wait%0d state", k), 64'(state_o), 64'(ST_FETCH));
         chk($sformatf("to_wait%0d timeout", k), 64'(timeout_o), 64'(k == WAIT_LIMIT - 1));
         chk($sformatf("to_wait%0d pc_write", k), 64'(pc_write_o), 64'(0));
      end
      // ready arriving in the limit cycle wins over the timeout
      for (int k = 0; k < WAIT_LIMIT - 1; k++) begin
         drive(0, OP_RTYPE, 0, 0);
         chk($sformatf("rl_wait%0d timeout", k), 64'(timeout_o), 64'(0));
      end
      drive(0, OP_RTYPE, 0, 1);
      chk("ready_at_limit outputs", 64'(act), 64'(e_fetch(1)));
      drive(0, OP_RTYPE, 0, 1);
      chk("ready_at_limit next", 64'(state_o), 64'(ST_DECODE));
      chk("ready_at_limit cnt", 64'(instr_cnt_o), 64'(0));

      // ---------------- random stimulus vs instruction-step model ----------------
      drive(1, OP_RTYPE, 0, 0);
      drive(1, OP_RTYPE, 0, 0);
      m_st = ST_RST; m_wait = 0; m_cnt = '0; m_plan.delete(); stall_left = 0;
      op = OP_RTYPE;
      for (int i = 0; i < 3000; i++) begin
         r = (i > 0) && ($urandom_range(0, 199) == 0);
         if (stall_left > 0) begin
            rdy = 1'b0; stall_left--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) stall_left = $urandom_range(13, 18);
         end
         z = 1'($urandom_range(0, 1));
         if (m_st == ST_FETCH || m_st == ST_RST) begin
            if ($urandom_range(0, 11) < 10) op = legal_ops[$urandom_range(0, 9)];
            else                            op = 6'($urandom_range(0, 63));
         end
         drive(r, op, z, rdy);

         exp_to  = (m_st == ST_FETCH || m_st == ST_MEM_RD || m_st == ST_MEM_WR) &&
                   !rdy && (m_wait == WAIT_LIMIT - 1);
         exp_pcw = (m_st == ST_FETCH && rdy) || (m_st == ST_JUMP) ||
                   (m_st == ST_BRANCH && ((op == OP_BEQ && z) || (op == OP_BNE && !z)));
         exp_flags = {exp_pcw,
                      (m_st == ST_FETCH || m_st == ST_MEM_RD),
                      (m_st == ST_MEM_WR),
                      (m_st == ST_MEM_WB || m_st == ST_R_WB || m_st == ST_I_WB),
                      (m_st == ST_DECODE && !tb_legal(op)),
                      exp_to};
         got_flags = {pc_write_o, mem_read_o, mem_write_o, reg_write_o, illegal_o, timeout_o};
         chk($sformatf("rnd%0d state", i), 64'(state_o), 64'(m_st));
         chk($sformatf("rnd%0d instr_cnt", i), 64'(instr_cnt_o), 64'(m_cnt));
         chk($sformatf("rnd%0d flags", i), 64'(got_flags), 64'(exp_flags));

         // advance the model by one clock
         if (r) begin
            m_st = ST_RST; m_wait = 0; m_cnt = '0; m_plan.delete();
         end else if (exp_to) begin
            m_st = ST_FETCH; m_wait = 0; m_plan.delete();
         end else begin
            done = !(m_st == ST_FETCH || m_st == ST_MEM_RD || m_st == ST_MEM_WR) || rdy;
            if (!done) begin
               m_wait++;
            end else begin
               m_wait = 0;
               case (m_st)
                  ST_RST:   m_st = ST_FETCH;
                  ST_FETCH: m_st = ST_DECODE;
                  ST_DECODE: begin
                     m_plan.delete();
                     case (op)
                        OP_RTYPE: begin m_plan.push_back(ST_R_EXEC); m_plan.push_back(ST_R_WB); end
                        OP_LW: begin
                           m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_RD);
                           m_plan.push_back(ST_MEM_WB);
                        end
                        OP_SW: begin m_plan.push_back(ST_MEM_ADDR); m_plan.push_back(ST_MEM_WR); end
                        OP_BEQ, OP_BNE: m_plan.push_back(ST_BRANCH);
                        OP_J: m_plan.push_back(ST_JUMP);
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                           m_plan.push_back(ST_I_EXEC); m_plan.push_back(ST_I_WB);
                        end
                        default: ;
                     endcase
                     if (m_plan.size() == 0) m_st = ST_FETCH;
                     else                    m_st = m_plan.pop_front();
                  end
                  default: begin
                     if (m_plan.size() > 0) m_st = m_plan.pop_front();
                     else begin
                        m_cnt = m_cnt + 1'b1;
                        m_st  = ST_FETCH;
                     end
                  end
               endcase
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
